// File: rtl/booth_dot_acc.sv
// rtl/booth_dot_acc.sv - dot-product accumulator around a combinational 32x32 unsigned multiplier
// Optional BOOTH_DOT_SAT_EN: accumulator saturates to all-ones on carry-out instead of wrapping.
module booth_dot_acc #(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 80,
  parameter int LEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len,
  output logic                 busy,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [WIDTH-1:0]     op_x,
  input  logic [WIDTH-1:0]     op_y,
  output logic [WIDTH-1:0]     mul_x,
  output logic [WIDTH-1:0]     mul_y,
  input  logic [2*WIDTH-1:0]   mul_result,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ACC_WIDTH-1:0] res_data,
  output logic                 res_ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               state, state_nx;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] count;
  logic [ACC_WIDTH-1:0] acc;
  logic                 pend;
  logic                 ovf;
  logic                 xfer;
  logic [ACC_WIDTH:0]   sum;

  // Extra top bit of the sum is the accumulator carry-out
  assign sum = {1'b0, acc} + (ACC_WIDTH+1)'(mul_result);

  always_comb begin
    state_nx  = state;
    busy      = (state != IDLE);
    op_ready  = (state == RUN) && (count < len_q);
    res_valid = (state == DONE);
    xfer      = op_valid && op_ready;
    case (state)
      IDLE: begin
        if (start) state_nx = (len != '0) ? RUN : DONE;
      end
      RUN: begin
        if (xfer && (count + LEN_WIDTH'(1) == len_q)) state_nx = DRAIN;
      end
      DRAIN: state_nx = DONE;
      DONE: begin
        if (res_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mul_x <= '0;
      mul_y <= '0;
      acc   <= '0;
      count <= '0;
      len_q <= '0;
      pend  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      pend  <= xfer;
      // The product registered last cycle is added one cycle after acceptance
      if (pend) begin
        if (sum[ACC_WIDTH]) begin
          ovf <= 1'b1;
`ifdef BOOTH_DOT_SAT_EN
          acc <= '1;
`else
          acc <= sum[ACC_WIDTH-1:0];
`endif
        end else begin
          acc <= sum[ACC_WIDTH-1:0];
        end
      end
      if (xfer) begin
        mul_x <= op_x;
        mul_y <= op_y;
        count <= count + LEN_WIDTH'(1);
      end
      if ((state == IDLE) && start) begin
        len_q <= len;
        count <= '0;
        acc   <= '0;
        ovf   <= 1'b0;
      end
    end
  end

  assign res_data = acc;
  assign res_ovf  = ovf;

endmodule
